// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: access-size codes, the
// FSM state encoding and a helper that decides whether an access is
// misaligned for its size.
package mem_access_unit_pkg;

  // Access size codes as presented by the MEM stage (3 behaves as word)
  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  // Access sequencer states
  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_REQ  = 2'd1,
    MA_DONE = 2'd2
  } ma_state_e;

  // Halfwords must sit on an even byte, words on a multiple of four.
  // Bytes can never be misaligned.
  function automatic logic size_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    case (size)
      MEM_SIZE_BYTE: mis = 1'b0;
      MEM_SIZE_HALF: mis = offset[0];
      default:       mis = |offset;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bus side of the memory access unit: a req/ack transaction channel to a
// variable-latency data RAM.
//   req    master -> slave  request, held until ack
//   we     master -> slave  write strobe
//   addr   master -> slave  word address (byte address [ADDR_WIDTH+1:2])
//   be     master -> slave  byte enables, bit i covers bits [8i+7:8i]
//   wdata  master -> slave  store data replicated into the enabled lanes
//   rdata  slave -> master  read data, valid together with ack
//   ack    slave -> master  single-cycle completion
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 30
) ();

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  ack;

  modport master (
    output req, we, addr, be, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output rdata, ack
  );

endinterface

// File: rtl/mem_access_unit_align.sv
// Purely combinational lane steering for the memory access unit.
// Ports:
//   size, sign    access size code and load sign-extension select
//   offset        byte address bits [1:0]
//   rdata         raw word returned by the RAM
//   dout          right-aligned store data from the pipeline
//   load_data     selected lane, sign- or zero-extended to 32 bits
//   be, wdata     byte enables and lane-replicated store data
//   misaligned    the access does not fit its natural alignment
module mem_access_unit_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] dout,
  output logic [31:0] load_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Pick the addressed lane out of the read word, extend it, and build the
  // matching byte enables and replicated store data. Replicating the store
  // data means the RAM only has to honour the byte enables.
  always_comb begin
    lane_byte  = rdata[{offset, 3'b000} +: 8];
    lane_half  = offset[1] ? rdata[31:16] : rdata[15:0];
    load_data  = rdata;
    be         = 4'b1111;
    wdata      = dout;
    misaligned = size_misaligned(size, offset);
    case (size)
      MEM_SIZE_BYTE: begin
        load_data = {{24{sign & lane_byte[7]}}, lane_byte};
        be        = 4'b0001 << offset;
        wdata     = {4{dout[7:0]}};
      end
      MEM_SIZE_HALF: begin
        load_data = {{16{sign & lane_half[15]}}, lane_half};
        be        = offset[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{dout[15:0]}};
      end
      default: begin
        load_data = rdata;
        be        = 4'b1111;
        wdata     = dout;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Bridges the MEM stage to a variable-latency data RAM. A MEM-stage request
// becomes one req/ack bus transaction; the pipeline is stalled until the
// access completes, a misaligned access is rejected without touching the
// bus, and a request that sees no ack within TIMEOUT cycles is aborted and
// flagged in the sticky bus_error.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   mem_ren, mem_wen      MEM-stage read / write request (both = write)
//   mem_size, mem_sign    access size and load sign-extension select
//   mem_addr, mem_dout    byte address and right-aligned store data
//   mem_din               aligned/extended load data, valid in DONE
//   mem_stall             hold IF..MEM while an access is in flight
//   misaligned            one-cycle pulse for a rejected access
//   bus_error             sticky timeout flag
//   bus                   req/ack bus to the RAM (master side)
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 30,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_ren,
  input  logic                mem_wen,
  input  logic [1:0]          mem_size,
  input  logic                mem_sign,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_dout,
  output logic [31:0]         mem_din,
  output logic                mem_stall,
  output logic                misaligned,
  output logic                bus_error,
  mem_access_unit_if.master   bus
);

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  ma_state_e             state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [31:0]           mem_din_q, mem_din_d;
  logic                  misaligned_q, misaligned_d;
  logic                  bus_error_q, bus_error_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]            bus_be_q, bus_be_d;
  logic [31:0]           bus_wdata_q, bus_wdata_d;

  logic [31:0]           align_load;
  logic [3:0]            align_be;
  logic [31:0]           align_wdata;
  logic                  align_mis;

  // The pipeline keeps the request inputs stable while stalled, so the
  // same steering logic serves both request launch and load completion.
  mem_access_unit_align u_align (
    .size       (mem_size),
    .sign       (mem_sign),
    .offset     (mem_addr[1:0]),
    .rdata      (bus.rdata),
    .dout       (mem_dout),
    .load_data  (align_load),
    .be         (align_be),
    .wdata      (align_wdata),
    .misaligned (align_mis)
  );

  // State, counter and every registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MA_IDLE;
      cnt_q        <= '0;
      mem_din_q    <= '0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_be_q     <= '0;
      bus_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_din_q    <= mem_din_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
    end
  end

  // Next-state logic. Stall is asserted combinationally in IDLE as soon as
  // a request appears so the pipeline freezes in the same cycle. DONE drops
  // the stall, letting the pipeline advance on that edge; the old request
  // still visible on the inputs there is deliberately ignored. An ack wins
  // over a timeout that would expire in the same cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_din_d    = mem_din_q;
    misaligned_d = 1'b0;
    bus_error_d  = bus_error_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    mem_stall    = 1'b0;

    case (state_q)
      MA_IDLE: begin
        if (mem_ren | mem_wen) begin
          mem_stall = 1'b1;
          if (align_mis) begin
            mem_din_d    = '0;
            misaligned_d = 1'b1;
            state_d      = MA_DONE;
          end else begin
            bus_addr_d  = mem_addr[ADDR_WIDTH+1:2];
            bus_we_d    = mem_wen;
            bus_be_d    = align_be;
            bus_wdata_d = align_wdata;
            bus_req_d   = 1'b1;
            cnt_d       = '0;
            state_d     = MA_REQ;
          end
        end
      end

      MA_REQ: begin
        mem_stall = 1'b1;
        if (bus.ack) begin
          bus_req_d = 1'b0;
          mem_din_d = bus_we_q ? 32'd0 : align_load;
          state_d   = MA_DONE;
        end else if (cnt_q == TIMEOUT_CNT) begin
          bus_req_d   = 1'b0;
          mem_din_d   = '0;
          bus_error_d = 1'b1;
          state_d     = MA_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      MA_DONE: begin
        state_d = MA_IDLE;
      end

      default: begin
        state_d = MA_IDLE;
      end
    endcase
  end

  assign mem_din    = mem_din_q;
  assign misaligned = misaligned_q;
  assign bus_error  = bus_error_q;
  assign bus.req    = bus_req_q;
  assign bus.we     = bus_we_q;
  assign bus.addr   = bus_addr_q;
  assign bus.be     = bus_be_q;
  assign bus.wdata  = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases followed by random
// loads/stores, all compared against a behavioural model of the access
// rules.
module tb_mem_access_unit;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic        mem_ren;
  logic        mem_wen;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        misaligned;
  logic        bus_error;

  int          n_checks;
  int          n_fail;
  logic        exp_err;
  logic [31:0] last_din;

  mem_access_unit_if #(.ADDR_WIDTH(30)) bus ();

  mem_access_unit #(
    .ADDR_WIDTH (30),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_size   (mem_size),
    .mem_sign   (mem_sign),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .mem_din    (mem_din),
    .mem_stall  (mem_stall),
    .misaligned (misaligned),
    .bus_error  (bus_error),
    .bus        (bus.master)
  );

  // 100 MHz-style free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a wedged run still ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: misalignment from the size's natural boundary
  function automatic logic modelMis(input logic [1:0] size, input logic [1:0] off);
    int bytes;
    bytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    return (int'(off) % bytes) != 0;
  endfunction

  // Reference model: load value = addressed field shifted down, masked, extended
  function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic sign,
                                            input logic [1:0] off, input logic [31:0] rdata);
    logic [31:0] v;
    logic [31:0] mask;
    int          width;
    if (size == 2'd0) width = 8;
    else if (size == 2'd1) width = 16;
    else return rdata;
    mask = (32'd1 << width) - 32'd1;
    v = (rdata >> (8 * int'(off))) & mask;
    if (sign && v[width-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] modelBe(input logic [1:0] size, input logic [1:0] off);
    if (size == 2'd0) return 4'(4'b0001 << off);
    if (size == 2'd1) return 4'(4'b0011 << off);
    return 4'b1111;
  endfunction

  function automatic logic [31:0] modelWdata(input logic [1:0] size, input logic [31:0] dout);
    if (size == 2'd0) return {24'd0, dout[7:0]} * 32'h0101_0101;
    if (size == 2'd1) return {16'd0, dout[15:0]} * 32'h0001_0001;
    return dout;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Run one access starting at a negedge with the DUT idle. ack_delay is the
  // REQ cycle index carrying bus_ack (negative = never ack). With hold set,
  // the request stays on the inputs through DONE, so the next call lands
  // back-to-back. Returns at a negedge with the DUT in IDLE.
  task automatic applyStimulus(input logic ren, input logic wen, input logic [1:0] size,
                               input logic sign, input logic [31:0] addr,
                               input logic [31:0] dout, input logic [31:0] rdata,
                               input int ack_delay, input bit hold);
    logic        mis;
    logic [31:0] exp_din;
    int          n_req;
    int          exp_stall;
    int          stalls;
    mis       = modelMis(size, addr[1:0]);
    n_req     = (ack_delay < 0) ? TIMEOUT + 1 : ack_delay + 1;
    exp_stall = mis ? 1 : n_req + 1;
    mem_ren   = ren;
    mem_wen   = wen;
    mem_size  = size;
    mem_sign  = sign;
    mem_addr  = addr;
    mem_dout  = dout;
    #1;
    stalls = 0;
    checkOutput("idle_stall", 32'(mem_stall), 32'd1);
    checkOutput("idle_req", 32'(bus.req), 32'd0);
    stalls += int'(mem_stall);
    @(negedge clk);
    if (!mis) begin
      for (int k = 0; k < n_req; k++) begin
        checkOutput("req_high", 32'(bus.req), 32'd1);
        checkOutput("req_addr", 32'(bus.addr), addr >> 2);
        checkOutput("req_we", 32'(bus.we), 32'(wen));
        checkOutput("req_be", 32'(bus.be), 32'(modelBe(size, addr[1:0])));
        if (wen) checkOutput("req_wdata", bus.wdata, modelWdata(size, dout));
        checkOutput("req_mis", 32'(misaligned), 32'd0);
        stalls += int'(mem_stall);
        if (k == ack_delay) begin
          bus.ack   = 1'b1;
          bus.rdata = rdata;
        end
        @(negedge clk);
        bus.ack   = 1'b0;
        bus.rdata = $urandom;
      end
      if (ack_delay < 0) exp_err = 1'b1;
    end
    exp_din = (mis || wen || ack_delay < 0) ? 32'd0 : modelLoad(size, sign, addr[1:0], rdata);
    checkOutput("done_stall", 32'(mem_stall), 32'd0);
    checkOutput("done_req", 32'(bus.req), 32'd0);
    checkOutput("done_mis", 32'(misaligned), 32'(mis));
    checkOutput("done_err", 32'(bus_error), 32'(exp_err));
    checkOutput("done_din", mem_din, exp_din);
    checkOutput("stall_cycles", 32'(stalls), 32'(exp_stall));
    last_din = mem_din;
    if (!hold) begin
      mem_ren = 1'b0;
      mem_wen = 1'b0;
    end
    @(negedge clk);
    if (!hold) begin
      checkOutput("after_stall", 32'(mem_stall), 32'd0);
      checkOutput("after_mis", 32'(misaligned), 32'd0);
    end
  endtask

  initial begin
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    int          r_op;
    n_checks  = 0;
    n_fail    = 0;
    exp_err   = 1'b0;
    last_din  = '0;
    rst       = 1'b1;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_size  = 2'd0;
    mem_sign  = 1'b0;
    mem_addr  = '0;
    mem_dout  = '0;
    bus.ack   = 1'b0;
    bus.rdata = '0;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_din", mem_din, 32'd0);
    checkOutput("rst_stall", 32'(mem_stall), 32'd0);
    checkOutput("rst_mis", 32'(misaligned), 32'd0);
    checkOutput("rst_err", 32'(bus_error), 32'd0);
    checkOutput("rst_req", 32'(bus.req), 32'd0);
    checkOutput("rst_we", 32'(bus.we), 32'd0);
    checkOutput("rst_addr", 32'(bus.addr), 32'd0);
    checkOutput("rst_be", 32'(bus.be), 32'd0);
    checkOutput("rst_wdata", bus.wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // LW 0x10, ack in the third REQ cycle: four stall cycles
    applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0, 32'hCAFE_F00D, 2, 1'b0);
    checkOutput("lw_din", last_din, 32'hCAFE_F00D);
    // LB / LBU at 0x13
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'd0, 32'h80FF_FF00, 0, 1'b0);
    checkOutput("lb_din", last_din, 32'hFFFF_FF80);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'd0, 32'h80FF_FF00, 1, 1'b0);
    checkOutput("lbu_din", last_din, 32'h0000_0080);
    // SH 0x22
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h1234_ABCD, 32'h5555_5555, 2, 1'b0);
    // LW 0x6 misaligned
    applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'd0, 32'h1111_1111, 0, 1'b0);
    // LH sign-extended from upper half, then back-to-back identical request
    applyStimulus(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'd0, 32'h9ABC_0000, 0, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'd0, 32'h9ABC_0000, 1, 1'b0);
    checkOutput("lh_din", last_din, 32'hFFFF_9ABC);
    // Timeout: no ack at all
    applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'd0, 32'd0, -1, 1'b0);

    // Random traffic; bus_error must stay set throughout
    for (int i = 0; i < 40; i++) begin
      r_op   = int'($urandom_range(0, 2));
      r_size = 2'($urandom_range(0, 3));
      r_addr = $urandom;
      applyStimulus(r_op != 1, r_op != 0, r_size, 1'($urandom_range(0, 1)), r_addr,
                    $urandom, $urandom, int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset while in REQ, then a stray late ack
    mem_ren  = 1'b1;
    mem_wen  = 1'b0;
    mem_size = 2'd2;
    mem_addr = 32'h0000_0040;
    @(negedge clk);
    checkOutput("rreq_req", 32'(bus.req), 32'd1);
    rst     = 1'b1;
    mem_ren = 1'b0;
    @(negedge clk);
    exp_err = 1'b0;
    checkOutput("rreq_req_low", 32'(bus.req), 32'd0);
    checkOutput("rreq_stall", 32'(mem_stall), 32'd0);
    checkOutput("rreq_err", 32'(bus_error), 32'd0);
    checkOutput("rreq_din", mem_din, 32'd0);
    rst       = 1'b0;
    bus.ack   = 1'b1;
    bus.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.ack = 1'b0;
    checkOutput("late_ack_din", mem_din, 32'd0);
    checkOutput("late_ack_req", 32'(bus.req), 32'd0);
    checkOutput("late_ack_stall", 32'(mem_stall), 32'd0);
    checkOutput("late_ack_mis", 32'(misaligned), 32'd0);
    // Normal access afterwards
    applyStimulus(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0044, 32'd0, 32'h1234_8765, 1, 1'b0);
    checkOutput("final_lhu", last_din, 32'h0000_8765);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
